// File: rtl/vx_matrix_gather_if.sv
// Dispatch packet interface between the dispatch stage and the matrix gather
// block.
//
// Handshake: a packet transfers on a rising clk edge where valid && ready.
// The master holds every payload field stable while valid is high and ready
// is low. The slave's ready never depends on valid.
//
// Fields:
//   valid, ready  - handshake
//   uuid, wis     - instruction uuid and issue-slot warp index
//   tmask         - per-lane thread mask
//   rd            - destination register
//   rs1_data      - per-lane A operand
//   rs2_data      - per-lane B operand
//   m_instr_cnt   - number of row packets in this matrix instruction
//   m_instr_id    - tag shared by every row packet of one instruction
//   m_type        - matrix operation type
//   m_row_size    - active lanes per row (0 means all lanes)
interface vx_dispatch_if #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 1,
  parameter int WIS_W       = 2,
  parameter int NR_BITS     = 5,
  parameter int M_TYPE_BITS = 2,
  parameter int CNT_W       = 8,
  parameter int ID_W        = 4,
  parameter int RS_W        = 4
);
  logic                                valid;
  logic                                ready;
  logic [UUID_WIDTH-1:0]               uuid;
  logic [WIS_W-1:0]                    wis;
  logic [NUM_THREADS-1:0]              tmask;
  logic [NR_BITS-1:0]                  rd;
  logic [NUM_THREADS-1:0][XLEN-1:0]    rs1_data;
  logic [NUM_THREADS-1:0][XLEN-1:0]    rs2_data;
  logic [CNT_W-1:0]                    m_instr_cnt;
  logic [ID_W-1:0]                     m_instr_id;
  logic [M_TYPE_BITS-1:0]              m_type;
  logic [RS_W-1:0]                     m_row_size;

  modport master (
    output valid, uuid, wis, tmask, rd, rs1_data, rs2_data,
           m_instr_cnt, m_instr_id, m_type, m_row_size,
    input  ready
  );

  modport slave (
    input  valid, uuid, wis, tmask, rd, rs1_data, rs2_data,
           m_instr_cnt, m_instr_id, m_type, m_row_size,
    output ready
  );
endinterface

// File: rtl/vx_matrix_gather.sv
// Matrix row gather: collects the per-row dispatch packets of one matrix
// instruction into an A/B row buffer and issues a single gathered request
// to the matrix core.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   dispatch_if   - incoming row packets (slave side)
//   req_valid/req_ready - gathered request handshake; fires on a clk edge
//                   with both high; all req_* are registered and held stable
//                   while req_valid is high and req_ready is low
//   req_uuid, req_wis, req_rd, req_m_type - context of the first packet
//   req_rows      - number of valid rows (1..MAX_ROWS)
//   req_a_data    - rows from rs1_data, row r at bit r*NUM_THREADS*XLEN
//   req_b_data    - rows from rs2_data, same layout
//   err_mismatch  - one-cycle pulse after a packet is dropped
//   busy          - high whenever not idle
//   dbg_state     - current FSM state
module vx_matrix_gather #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int MAX_ROWS    = 8,
  parameter int UUID_WIDTH  = 1,
  parameter int WIS_W       = 2,
  parameter int NR_BITS     = 5,
  parameter int M_TYPE_BITS = 2,
  parameter int ID_W        = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  vx_dispatch_if.slave                        dispatch_if,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [UUID_WIDTH-1:0]               req_uuid,
  output logic [WIS_W-1:0]                    req_wis,
  output logic [NR_BITS-1:0]                  req_rd,
  output logic [M_TYPE_BITS-1:0]              req_m_type,
  output logic [3:0]                          req_rows,
  output logic [MAX_ROWS*NUM_THREADS*XLEN-1:0] req_a_data,
  output logic [MAX_ROWS*NUM_THREADS*XLEN-1:0] req_b_data,
  output logic                                err_mismatch,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;

  localparam int ROW_W = NUM_THREADS * XLEN;
  localparam int IDX_W = $clog2(MAX_ROWS);

  logic [1:0]                         state;
  logic [3:0]                         row_cnt;
  logic [3:0]                         target;
  logic [ID_W-1:0]                    id_q;
  logic [MAX_ROWS-1:0][ROW_W-1:0]     a_buf;
  logic [MAX_ROWS-1:0][ROW_W-1:0]     b_buf;
  logic                               err_q;

  logic                               accept;
  logic                               match;
  logic [3:0]                         row_nxt;
  logic [3:0]                         cnt_clamp;
  logic [IDX_W-1:0]                   row_idx;
  logic [NUM_THREADS-1:0][XLEN-1:0]   row_a;
  logic [NUM_THREADS-1:0][XLEN-1:0]   row_b;

  // ready is decoded from the registered state only
  assign dispatch_if.ready = (state == S_IDLE) || (state == S_GATHER);
  assign accept  = dispatch_if.valid && dispatch_if.ready;
  assign match   = (dispatch_if.m_instr_id == id_q) && (dispatch_if.wis == req_wis);
  assign row_nxt = row_cnt + 4'd1;
  assign row_idx = row_cnt[IDX_W-1:0];

  // Row count clamped to 1..MAX_ROWS so row_cnt can never run past the buffer
  always_comb begin
    cnt_clamp = dispatch_if.m_instr_cnt[3:0];
    if (dispatch_if.m_instr_cnt == '0)
      cnt_clamp = 4'd1;
    else if (int'(dispatch_if.m_instr_cnt) > MAX_ROWS)
      cnt_clamp = 4'(MAX_ROWS);
  end

  // Lane t is kept only when its mask bit is set and it lies inside the
  // effective row size (0 or oversize means the full row)
  always_comb begin
    int eff;
    eff = NUM_THREADS;
    if (dispatch_if.m_row_size != '0 && int'(dispatch_if.m_row_size) <= NUM_THREADS)
      eff = int'(dispatch_if.m_row_size);
    row_a = '0;
    row_b = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (dispatch_if.tmask[t] && (t < eff)) begin
        row_a[t] = dispatch_if.rs1_data[t];
        row_b[t] = dispatch_if.rs2_data[t];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      target     <= '0;
      id_q       <= '0;
      a_buf      <= '0;
      b_buf      <= '0;
      err_q      <= 1'b0;
      req_uuid   <= '0;
      req_wis    <= '0;
      req_rd     <= '0;
      req_m_type <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Clear the whole buffer so unused rows read as zero, then row 0
            a_buf      <= '0;
            b_buf      <= '0;
            a_buf[0]   <= row_a;
            b_buf[0]   <= row_b;
            req_uuid   <= dispatch_if.uuid;
            req_wis    <= dispatch_if.wis;
            req_rd     <= dispatch_if.rd;
            req_m_type <= dispatch_if.m_type;
            id_q       <= dispatch_if.m_instr_id;
            target     <= cnt_clamp;
            row_cnt    <= 4'd1;
            state      <= (cnt_clamp == 4'd1) ? S_ISSUE : S_GATHER;
          end
        end
        S_GATHER: begin
          if (accept) begin
            if (match) begin
              a_buf[row_idx] <= row_a;
              b_buf[row_idx] <= row_b;
              row_cnt        <= row_nxt;
              if (row_nxt == target)
                state <= S_ISSUE;
            end else begin
              // Foreign packet: consumed and dropped, nothing else changes
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (req_ready) begin
            state   <= S_IDLE;
            row_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_valid    = (state == S_ISSUE);
  assign req_rows     = row_cnt;
  assign req_a_data   = a_buf;
  assign req_b_data   = b_buf;
  assign err_mismatch = err_q;
  assign busy         = (state != S_IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_vx_matrix_gather.sv
module tb_vx_matrix_gather;
  localparam int NT    = 4;
  localparam int XL    = 32;
  localparam int MR    = 8;
  localparam int ROW_W = NT * XL;
  localparam int BUF_W = MR * ROW_W;
  localparam int EXP_W = 10 + 4 + 2 * BUF_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_dispatch_if #(.NUM_THREADS(NT), .XLEN(XL)) disp();

  logic             req_valid;
  logic             req_ready;
  logic [0:0]       req_uuid;
  logic [1:0]       req_wis;
  logic [4:0]       req_rd;
  logic [1:0]       req_m_type;
  logic [3:0]       req_rows;
  logic [BUF_W-1:0] req_a_data;
  logic [BUF_W-1:0] req_b_data;
  logic             err_mismatch;
  logic             busy;
  logic [1:0]       dbg_state;

  vx_matrix_gather #(.NUM_THREADS(NT), .XLEN(XL), .MAX_ROWS(MR)) dut (
    .clk          (clk),
    .reset        (reset),
    .dispatch_if  (disp),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_uuid     (req_uuid),
    .req_wis      (req_wis),
    .req_rd       (req_rd),
    .req_m_type   (req_m_type),
    .req_rows     (req_rows),
    .req_a_data   (req_a_data),
    .req_b_data   (req_b_data),
    .err_mismatch (err_mismatch),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // scoreboard state
  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [BUF_W-1:0] exp_a;
  logic [BUF_W-1:0] exp_b;
  logic [0:0]       cur_uuid;
  logic [1:0]       cur_wis;
  logic [4:0]       cur_rd;
  logic [1:0]       cur_mtype;

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [ROW_W-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                             input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic set_row(input int r, input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    exp_a[r*ROW_W +: ROW_W] = a;
    exp_b[r*ROW_W +: ROW_W] = b;
  endtask

  task automatic clear_exp();
    exp_a = '0;
    exp_b = '0;
  endtask

  task automatic push_exp(input logic [3:0] rows);
    exp_q.push_back({cur_uuid, cur_wis, cur_rd, cur_mtype, rows, exp_a, exp_b});
  endtask

  // Drives one packet; returns at posedge+1 of the accepting edge.
  task automatic send_pkt(input logic [3:0] id, input logic [7:0] cnt, input logic [3:0] tmask,
                          input logic [3:0] rsz, input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    logic ok;
    logic rdy;
    disp.valid       = 1'b1;
    disp.uuid        = cur_uuid;
    disp.wis         = cur_wis;
    disp.rd          = cur_rd;
    disp.m_type      = cur_mtype;
    disp.m_instr_id  = id;
    disp.m_instr_cnt = cnt;
    disp.tmask       = tmask;
    disp.m_row_size  = rsz;
    disp.rs1_data    = a;
    disp.rs2_data    = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = disp.ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    disp.valid = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // monitor: pops one expected request per fire
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", req_rows, 4'hf);
      end else begin
        e = exp_q.pop_front();
        check("req_ctx", {req_uuid, req_wis, req_rd, req_m_type}, e[EXP_W-1 -: 10]);
        check("req_rows", req_rows, e[2*BUF_W +: 4]);
        for (int r = 0; r < MR; r++) begin
          check($sformatf("req_a_row%0d", r), req_a_data[r*ROW_W +: ROW_W], e[BUF_W + r*ROW_W +: ROW_W]);
          check($sformatf("req_b_row%0d", r), req_b_data[r*ROW_W +: ROW_W], e[r*ROW_W +: ROW_W]);
        end
      end
    end
    if (err_mismatch) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUF_W-1:0] snap_a;
    logic [ROW_W-1:0] snap_ctx;
    int               pulses0;

    reset = 1'b1;
    req_ready = 1'b0;
    disp.valid = 1'b0;
    disp.uuid = '0; disp.wis = '0; disp.rd = '0; disp.m_type = '0;
    disp.m_instr_id = '0; disp.m_instr_cnt = '0; disp.tmask = '0;
    disp.m_row_size = '0; disp.rs1_data = '0; disp.rs2_data = '0;
    cur_uuid = '0; cur_wis = '0; cur_rd = '0; cur_mtype = '0;
    clear_exp();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_mismatch, 1'b0);
    check("rst_rows", req_rows, 4'd0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_a_zero", |req_a_data, 1'b0);
    check("rst_ready", disp.ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single row
    cur_uuid = 1'b1; cur_wis = 2'd1; cur_rd = 5'd3; cur_mtype = 2'd1;
    req_ready = 1'b1;
    clear_exp();
    set_row(0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8));
    push_exp(4'd1);
    send_pkt(4'd1, 8'd1, 4'hf, 4'd0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8));
    check("t1_latency", req_valid, 1'b1);
    check("t1_ready_low", disp.ready, 1'b0);
    wait_idle("t1_idle");

    // four rows with backpressure
    cur_uuid = 1'b0; cur_wis = 2'd2; cur_rd = 5'd7; cur_mtype = 2'd2;
    req_ready = 1'b0;
    clear_exp();
    for (int r = 0; r < 4; r++)
      set_row(r, lanes(32'h100 + 16*r, 32'h101 + 16*r, 32'h102 + 16*r, 32'h103 + 16*r),
                 lanes(32'h200 + 16*r, 32'h201 + 16*r, 32'h202 + 16*r, 32'h203 + 16*r));
    push_exp(4'd4);
    for (int r = 0; r < 4; r++)
      send_pkt(4'd5, 8'd4, 4'hf, 4'd0,
               lanes(32'h100 + 16*r, 32'h101 + 16*r, 32'h102 + 16*r, 32'h103 + 16*r),
               lanes(32'h200 + 16*r, 32'h201 + 16*r, 32'h202 + 16*r, 32'h203 + 16*r));
    check("t2_latency", req_valid, 1'b1);
    snap_a   = req_a_data;
    snap_ctx = {req_uuid, req_wis, req_rd, req_m_type, req_rows};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_ready", disp.ready, 1'b0);
      check("t2_stall_valid", req_valid, 1'b1);
      check("t2_stable_a", req_a_data === snap_a, 1'b1);
      check("t2_stable_ctx", {req_uuid, req_wis, req_rd, req_m_type, req_rows}, snap_ctx);
      @(posedge clk);
      #1;
    end
    req_ready = 1'b1;
    wait_idle("t2_idle");

    // mismatch: ids 2,7,2,2 with count 3
    cur_uuid = 1'b1; cur_wis = 2'd0; cur_rd = 5'd9; cur_mtype = 2'd3;
    pulses0 = err_pulses;
    clear_exp();
    set_row(0, lanes(32'ha0, 32'ha1, 32'ha2, 32'ha3), lanes(32'h10a0, 32'h10a1, 32'h10a2, 32'h10a3));
    set_row(1, lanes(32'hb0, 32'hb1, 32'hb2, 32'hb3), lanes(32'h10b0, 32'h10b1, 32'h10b2, 32'h10b3));
    set_row(2, lanes(32'hc0, 32'hc1, 32'hc2, 32'hc3), lanes(32'h10c0, 32'h10c1, 32'h10c2, 32'h10c3));
    push_exp(4'd3);
    send_pkt(4'd2, 8'd3, 4'hf, 4'd0, lanes(32'ha0, 32'ha1, 32'ha2, 32'ha3),
             lanes(32'h10a0, 32'h10a1, 32'h10a2, 32'h10a3));
    send_pkt(4'd7, 8'd3, 4'hf, 4'd0, lanes(32'hdead, 32'hdead, 32'hdead, 32'hdead),
             lanes(32'hdead, 32'hdead, 32'hdead, 32'hdead));
    check("t3_err_pulse", err_mismatch, 1'b1);
    check("t3_still_gather", dbg_state, 2'd1);
    send_pkt(4'd2, 8'd3, 4'hf, 4'd0, lanes(32'hb0, 32'hb1, 32'hb2, 32'hb3),
             lanes(32'h10b0, 32'h10b1, 32'h10b2, 32'h10b3));
    check("t3_err_clear", err_mismatch, 1'b0);
    send_pkt(4'd2, 8'd3, 4'hf, 4'd0, lanes(32'hc0, 32'hc1, 32'hc2, 32'hc3),
             lanes(32'h10c0, 32'h10c1, 32'h10c2, 32'h10c3));
    check("t3_latency", req_valid, 1'b1);
    wait_idle("t3_idle");
    check("t3_err_count", err_pulses - pulses0, 1);

    // masking and row size
    cur_uuid = 1'b0; cur_wis = 2'd3; cur_rd = 5'd1; cur_mtype = 2'd0;
    clear_exp();
    set_row(0, lanes(9, 0, 9, 0), lanes(9, 0, 9, 0));
    set_row(1, lanes(9, 0, 0, 0), lanes(9, 0, 0, 0));
    set_row(2, lanes(9, 9, 9, 9), lanes(9, 9, 9, 9));
    set_row(3, lanes(0, 9, 0, 9), lanes(0, 9, 0, 9));
    push_exp(4'd4);
    send_pkt(4'd3, 8'd4, 4'b0101, 4'd3, lanes(9, 9, 9, 9), lanes(9, 9, 9, 9));
    send_pkt(4'd3, 8'd4, 4'b1111, 4'd1, lanes(9, 9, 9, 9), lanes(9, 9, 9, 9));
    send_pkt(4'd3, 8'd4, 4'b1111, 4'd6, lanes(9, 9, 9, 9), lanes(9, 9, 9, 9));
    send_pkt(4'd3, 8'd4, 4'b1010, 4'd4, lanes(9, 9, 9, 9), lanes(9, 9, 9, 9));
    wait_idle("t4_idle");

    // count clamp: 12 -> 8 rows
    cur_uuid = 1'b1; cur_wis = 2'd1; cur_rd = 5'd20; cur_mtype = 2'd1;
    clear_exp();
    for (int r = 0; r < 8; r++)
      set_row(r, lanes(32'h300 + r, 32'h310 + r, 32'h320 + r, 32'h330 + r),
                 lanes(32'h400 + r, 32'h410 + r, 32'h420 + r, 32'h430 + r));
    push_exp(4'd8);
    for (int r = 0; r < 8; r++) begin
      send_pkt(4'd9, 8'd12, 4'hf, 4'd0,
               lanes(32'h300 + r, 32'h310 + r, 32'h320 + r, 32'h330 + r),
               lanes(32'h400 + r, 32'h410 + r, 32'h420 + r, 32'h430 + r));
      if (r == 6) check("t5_no_early_issue", req_valid, 1'b0);
    end
    check("t5_latency", req_valid, 1'b1);
    wait_idle("t5_idle");

    // zero count -> single row
    clear_exp();
    set_row(0, lanes(32'h55, 32'h56, 32'h57, 32'h58), lanes(32'h65, 32'h66, 32'h67, 32'h68));
    push_exp(4'd1);
    send_pkt(4'd4, 8'd0, 4'hf, 4'd0, lanes(32'h55, 32'h56, 32'h57, 32'h58),
             lanes(32'h65, 32'h66, 32'h67, 32'h68));
    check("t5_zero_latency", req_valid, 1'b1);
    wait_idle("t5_zero_idle");

    // reset mid-gather after 2 of 4 rows
    cur_uuid = 1'b0; cur_wis = 2'd2; cur_rd = 5'd11; cur_mtype = 2'd2;
    send_pkt(4'd6, 8'd4, 4'hf, 4'd0, lanes(32'hee, 32'hee, 32'hee, 32'hee),
             lanes(32'hee, 32'hee, 32'hee, 32'hee));
    send_pkt(4'd6, 8'd4, 4'hf, 4'd0, lanes(32'hef, 32'hef, 32'hef, 32'hef),
             lanes(32'hef, 32'hef, 32'hef, 32'hef));
    check("t6_gathering", dbg_state, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", req_valid, 1'b0);
    check("t6_rst_rows", req_rows, 4'd0);
    check("t6_rst_a_zero", |req_a_data, 1'b0);
    check("t6_rst_b_zero", |req_b_data, 1'b0);
    check("t6_rst_ctx", {req_uuid, req_wis, req_rd, req_m_type}, 10'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cur_uuid = 1'b1; cur_wis = 2'd0; cur_rd = 5'd2; cur_mtype = 2'd3;
    clear_exp();
    set_row(0, lanes(32'h11, 32'h12, 32'h13, 32'h14), lanes(32'h21, 32'h22, 32'h23, 32'h24));
    push_exp(4'd1);
    send_pkt(4'd1, 8'd1, 4'hf, 4'd0, lanes(32'h11, 32'h12, 32'h13, 32'h14),
             lanes(32'h21, 32'h22, 32'h23, 32'h24));
    check("t6_latency", req_valid, 1'b1);
    wait_idle("t6_idle");

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
